// File: rtl/motor_loop_seq_if.sv
// Feedback-read, PID and DAC handshake bundle of motor_loop_seq.
// Signal suffixes are seen from the sequencer (master) side.
interface motor_loop_seq_if;
  logic        rd_req_o;
  logic        ufeed_en_i;
  logic        pid_start_o;
  logic        pid_done_i;
  logic [15:0] pid_data_i;
  logic        dac_wr_en_o;
  logic [15:0] dac_data_o;
  logic        dac_ack_i;

  modport master (
    output rd_req_o,
    output pid_start_o,
    output dac_wr_en_o,
    output dac_data_o,
    input  ufeed_en_i,
    input  pid_done_i,
    input  pid_data_i,
    input  dac_ack_i
  );

  modport slave (
    input  rd_req_o,
    input  pid_start_o,
    input  dac_wr_en_o,
    input  dac_data_o,
    output ufeed_en_i,
    output pid_done_i,
    output pid_data_i,
    output dac_ack_i
  );
endinterface

// File: rtl/motor_loop_seq.sv
// Tick-paced motor control loop: sample Ufeed, run PID, write DAC,
// with per-phase timeouts and dropped-tick (overrun) accounting.
module motor_loop_seq #(
  parameter int unsigned PERIOD_100HZ = 1000000,
  parameter int unsigned PERIOD_200HZ = 500000,
  parameter int unsigned PERIOD_300HZ = 333333,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              loop_en_i,
  input  logic [1:0]        motor_freq_i,
  input  logic              err_clr_i,
  motor_loop_seq_if.master  bus,
  output logic              busy_o,
  output logic [2:0]        state_o,
  output logic              timeout_err_o,
  output logic [15:0]       overrun_cnt_o
);

  localparam int unsigned PM01 =
    (PERIOD_100HZ > PERIOD_200HZ) ? PERIOD_100HZ : PERIOD_200HZ;
  localparam int unsigned PMAX =
    (PM01 > PERIOD_300HZ) ? PM01 : PERIOD_300HZ;
  localparam int CW = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int PW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    READ      = 3'd2,
    WAIT_FEED = 3'd3,
    CALC      = 3'd4,
    WRITE     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;
  logic [1:0]    freq_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   dac_q, dac_d;
  logic [15:0]   ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic          tick;
  logic          timed;
  logic          tmo_evt;
  logic          load;
  logic          busy;

  always_comb begin
    last = '0;
    case (motor_freq_i)
      2'd0:    last = CW'(PERIOD_100HZ - 1);
      2'd1:    last = CW'(PERIOD_200HZ - 1);
      2'd2:    last = CW'(PERIOD_300HZ - 1);
      default: last = '0;
    endcase
  end

  // A rate change restarts the period from zero without ticking.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    tick  = 1'b0;
    if (motor_freq_i != freq_q || motor_freq_i == 2'd3) begin
      cnt_d = '0;
    end else if (cnt_q == last) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  assign timed = (phase_q == PW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    tmo_evt = 1'b0;
    load    = 1'b0;
    if (!loop_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = WAIT_TICK;
        WAIT_TICK: if (tick) state_d = READ;
        READ:      state_d = WAIT_FEED;
        WAIT_FEED: begin
          if (bus.ufeed_en_i) begin
            state_d = CALC;
          end else if (timed) begin
            state_d = WAIT_TICK;
            tmo_evt = 1'b1;
          end
        end
        CALC: begin
          if (bus.pid_done_i) begin
            state_d = WRITE;
            load    = 1'b1;
          end else if (timed) begin
            state_d = WAIT_TICK;
            tmo_evt = 1'b1;
          end
        end
        WRITE: begin
          if (bus.dac_ack_i) begin
            state_d = WAIT_TICK;
          end else if (timed) begin
            state_d = WAIT_TICK;
            tmo_evt = 1'b1;
          end
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == READ) || (state_q == WAIT_FEED) ||
                (state_q == CALC) || (state_q == WRITE);

  always_comb begin
    phase_d = phase_q;
    if (state_d != state_q) begin
      phase_d = '0;
    end else if (state_q == WAIT_FEED || state_q == CALC ||
                 state_q == WRITE) begin
      phase_d = phase_q + PW'(1);
    end
  end

  // New events take priority over a coincident clear.
  always_comb begin
    dac_d = load ? bus.pid_data_i : dac_q;
    tmo_d = tmo_q;
    ovr_d = ovr_q;
    if (tmo_evt)        tmo_d = 1'b1;
    else if (err_clr_i) tmo_d = 1'b0;
    if (tick && busy) begin
      if (err_clr_i)             ovr_d = 16'd1;
      else if (ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
    end else if (err_clr_i) begin
      ovr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      dac_q   <= '0;
      ovr_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      freq_q  <= motor_freq_i;
      phase_q <= phase_d;
      dac_q   <= dac_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  // Strobes decode the state register so reset clears them at once.
  assign bus.rd_req_o    = (state_q == READ);
  assign bus.pid_start_o = (state_q == CALC) && (phase_q == '0);
  assign bus.dac_wr_en_o = (state_q == WRITE);
  assign bus.dac_data_o  = dac_q;
  assign busy_o          = busy;
  assign state_o         = state_q;
  assign timeout_err_o   = tmo_q;
  assign overrun_cnt_o   = ovr_q;

endmodule

// File: tb/tb_motor_loop_seq.sv
// Directed bench for motor_loop_seq: main instance with TIMEOUT_CYC=16,
// second instance with TIMEOUT_CYC=256 for the overrun scenario.
module tb_motor_loop_seq;
  logic clk = 1'b0;
  logic rst;
  logic loop_en, err_clr, busy, tmo;
  logic [1:0] freq;
  logic [2:0] state;
  logic [15:0] ovr;
  logic loop_en2, err_clr2, busy2, tmo2;
  logic [1:0] freq2;
  logic [2:0] state2;
  logic [15:0] ovr2;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int ps_cnt = 0;

  motor_loop_seq_if u_if ();
  motor_loop_seq_if u_if2 ();

  motor_loop_seq #(
    .PERIOD_100HZ(100), .PERIOD_200HZ(50),
    .PERIOD_300HZ(33), .TIMEOUT_CYC(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .loop_en_i(loop_en),
    .motor_freq_i(freq), .err_clr_i(err_clr), .bus(u_if),
    .busy_o(busy), .state_o(state), .timeout_err_o(tmo),
    .overrun_cnt_o(ovr)
  );

  motor_loop_seq #(
    .PERIOD_100HZ(100), .PERIOD_200HZ(50),
    .PERIOD_300HZ(33), .TIMEOUT_CYC(256)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst), .loop_en_i(loop_en2),
    .motor_freq_i(freq2), .err_clr_i(err_clr2), .bus(u_if2),
    .busy_o(busy2), .state_o(state2), .timeout_err_o(tmo2),
    .overrun_cnt_o(ovr2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (u_if.rd_req_o) rd_cnt++;
    if (u_if.pid_start_o) ps_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (state == 3'd2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; loop_en = 1'b0; freq = 2'd0; err_clr = 1'b0;
    u_if.ufeed_en_i = 1'b0; u_if.pid_done_i = 1'b0;
    u_if.pid_data_i = 16'h0; u_if.dac_ack_i = 1'b0;
    loop_en2 = 1'b0; freq2 = 2'd1; err_clr2 = 1'b0;
    u_if2.ufeed_en_i = 1'b0; u_if2.pid_done_i = 1'b0;
    u_if2.pid_data_i = 16'h0; u_if2.dac_ack_i = 1'b0;
    step();
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (u_if.rd_req_o !== 1'b0) begin errors++; $display("FAIL rst_rd_req got=%b exp=0", u_if.rd_req_o); end
    checks++; if (u_if.pid_start_o !== 1'b0) begin errors++; $display("FAIL rst_pid_start got=%b exp=0", u_if.pid_start_o); end
    checks++; if (u_if.dac_wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", u_if.dac_wr_en_o); end
    checks++; if (u_if.dac_data_o !== 16'h0) begin errors++; $display("FAIL rst_dac_data got=%h exp=0000", u_if.dac_data_o); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_tmo got=%b exp=0", tmo); end
    checks++; if (ovr !== 16'h0) begin errors++; $display("FAIL rst_ovr got=%0d exp=0", ovr); end
    checks++; if (state2 !== 3'd0) begin errors++; $display("FAIL rst_state2 got=%0d exp=0", state2); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    bit ok;
    loop_en2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (state2 == 3'd2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ovr_wait_read got=timeout exp=READ"); end
    step();
    u_if2.ufeed_en_i = 1'b1; step(); u_if2.ufeed_en_i = 1'b0;
    u_if2.pid_done_i = 1'b1; u_if2.pid_data_i = 16'h0777;
    step(); u_if2.pid_done_i = 1'b0;
    checks++; if (state2 !== 3'd5) begin errors++; $display("FAIL ovr_in_write got=%0d exp=5", state2); end
    repeat (120) step();
    checks++; if (state2 !== 3'd5) begin errors++; $display("FAIL ovr_hold_write got=%0d exp=5", state2); end
    checks++; if (ovr2 !== 16'd2) begin errors++; $display("FAIL ovr_count got=%0d exp=2", ovr2); end
    u_if2.dac_ack_i = 1'b1; step(); u_if2.dac_ack_i = 1'b0;
    checks++; if (state2 !== 3'd1) begin errors++; $display("FAIL ovr_after_ack got=%0d exp=1", state2); end
    checks++; if (ovr2 !== 16'd2) begin errors++; $display("FAIL ovr_no_queue got=%0d exp=2", ovr2); end
    err_clr2 = 1'b1; step(); err_clr2 = 1'b0;
    checks++; if (ovr2 !== 16'd0) begin errors++; $display("FAIL ovr_clear got=%0d exp=0", ovr2); end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (state2 == 3'd2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ovr_wait_read2 got=timeout exp=READ"); end
    step();
    repeat (48) step();
    err_clr2 = 1'b1; step(); err_clr2 = 1'b0;
    checks++; if (ovr2 !== 16'd1) begin errors++; $display("FAIL ovr_clr_coincide got=%0d exp=1", ovr2); end
    loop_en2 = 1'b0;
    step();
  endtask

  task automatic test_normal();
    bit ok;
    int t_read[2];
    int rd0, ps0;
    rd0 = rd_cnt; ps0 = ps_cnt;
    loop_en = 1'b1;
    for (int it = 0; it < 2; it++) begin
      wait_read(150, ok);
      checks++; if (!ok) begin errors++; $display("FAIL nrm_wait_read got=timeout exp=READ"); end
      t_read[it] = cyc;
      checks++; if (u_if.rd_req_o !== 1'b1) begin errors++; $display("FAIL nrm_rd_req got=%b exp=1", u_if.rd_req_o); end
      step();
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL nrm_wait_feed got=%0d exp=3", state); end
      step(); step();
      u_if.ufeed_en_i = 1'b1; step(); u_if.ufeed_en_i = 1'b0;
      checks++; if (state !== 3'd4 || u_if.pid_start_o !== 1'b1) begin errors++; $display("FAIL nrm_calc_start got=%0d/%b exp=4/1", state, u_if.pid_start_o); end
      step();
      checks++; if (u_if.pid_start_o !== 1'b0) begin errors++; $display("FAIL nrm_start_pulse got=%b exp=0", u_if.pid_start_o); end
      step(); step(); step();
      u_if.pid_done_i = 1'b1; u_if.pid_data_i = 16'h1234;
      step(); u_if.pid_done_i = 1'b0;
      checks++; if (state !== 3'd5 || u_if.dac_wr_en_o !== 1'b1) begin errors++; $display("FAIL nrm_write got=%0d/%b exp=5/1", state, u_if.dac_wr_en_o); end
      checks++; if (u_if.dac_data_o !== 16'h1234) begin errors++; $display("FAIL nrm_dac_data got=%h exp=1234", u_if.dac_data_o); end
      step();
      u_if.dac_ack_i = 1'b1; step(); u_if.dac_ack_i = 1'b0;
      checks++; if (state !== 3'd1 || u_if.dac_wr_en_o !== 1'b0) begin errors++; $display("FAIL nrm_ack got=%0d/%b exp=1/0", state, u_if.dac_wr_en_o); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL nrm_tmo got=%b exp=0", tmo); end
    end
    checks++; if (t_read[1] - t_read[0] != 100) begin errors++; $display("FAIL nrm_period got=%0d exp=100", t_read[1] - t_read[0]); end
    checks++; if (rd_cnt - rd0 != 2) begin errors++; $display("FAIL nrm_rd_count got=%0d exp=2", rd_cnt - rd0); end
    checks++; if (ps_cnt - ps0 != 2) begin errors++; $display("FAIL nrm_ps_count got=%0d exp=2", ps_cnt - ps0); end
    u_if.ufeed_en_i = 1'b1; u_if.pid_done_i = 1'b1;
    u_if.dac_ack_i = 1'b1; u_if.pid_data_i = 16'hAAAA;
    step();
    u_if.ufeed_en_i = 1'b0; u_if.pid_done_i = 1'b0; u_if.dac_ack_i = 1'b0;
    checks++; if (state !== 3'd1 || u_if.dac_data_o !== 16'h1234) begin errors++; $display("FAIL nrm_ignore got=%0d/%h exp=1/1234", state, u_if.dac_data_o); end
    checks++; if (ovr !== 16'd0) begin errors++; $display("FAIL nrm_ovr got=%0d exp=0", ovr); end
  endtask

  task automatic test_timeout();
    bit ok;
    wait_read(150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_wait_read got=timeout exp=READ"); end
    step();
    u_if.ufeed_en_i = 1'b1; step(); u_if.ufeed_en_i = 1'b0;
    repeat (15) step();
    checks++; if (state !== 3'd4 || tmo !== 1'b0) begin errors++; $display("FAIL tmo_early got=%0d/%b exp=4/0", state, tmo); end
    step();
    checks++; if (tmo !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL tmo_fire got=%b/%0d exp=1/1", tmo, state); end
    checks++; if (u_if.dac_data_o !== 16'h1234) begin errors++; $display("FAIL tmo_dac_hold got=%h exp=1234", u_if.dac_data_o); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", tmo); end
    wait_read(150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_wait_read2 got=timeout exp=READ"); end
    step();
    repeat (15) step();
    u_if.ufeed_en_i = 1'b1; step(); u_if.ufeed_en_i = 1'b0;
    checks++; if (state !== 3'd4 || tmo !== 1'b0) begin errors++; $display("FAIL tmo_tie_feed got=%0d/%b exp=4/0", state, tmo); end
    repeat (15) step();
    u_if.pid_done_i = 1'b1; u_if.pid_data_i = 16'hBEEF;
    step(); u_if.pid_done_i = 1'b0;
    checks++; if (state !== 3'd5 || tmo !== 1'b0) begin errors++; $display("FAIL tmo_tie_pid got=%0d/%b exp=5/0", state, tmo); end
    checks++; if (u_if.dac_data_o !== 16'hBEEF) begin errors++; $display("FAIL tmo_tie_data got=%h exp=beef", u_if.dac_data_o); end
    u_if.dac_ack_i = 1'b1; step(); u_if.dac_ack_i = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL tmo_tie_ack got=%0d exp=1", state); end
  endtask

  task automatic test_abort();
    bit ok;
    wait_read(150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abt_wait_read got=timeout exp=READ"); end
    step();
    u_if.ufeed_en_i = 1'b1; step(); u_if.ufeed_en_i = 1'b0;
    u_if.pid_done_i = 1'b1; u_if.pid_data_i = 16'h5555;
    step(); u_if.pid_done_i = 1'b0;
    checks++; if (state !== 3'd5 || u_if.dac_wr_en_o !== 1'b1) begin errors++; $display("FAIL abt_write got=%0d/%b exp=5/1", state, u_if.dac_wr_en_o); end
    loop_en = 1'b0; step();
    checks++; if (state !== 3'd0 || u_if.dac_wr_en_o !== 1'b0) begin errors++; $display("FAIL abt_idle got=%0d/%b exp=0/0", state, u_if.dac_wr_en_o); end
    checks++; if (u_if.dac_data_o !== 16'h5555) begin errors++; $display("FAIL abt_data got=%h exp=5555", u_if.dac_data_o); end
    u_if.dac_ack_i = 1'b1; step(); u_if.dac_ack_i = 1'b0;
    checks++; if (state !== 3'd0 || u_if.dac_data_o !== 16'h5555) begin errors++; $display("FAIL abt_late_ack got=%0d/%h exp=0/5555", state, u_if.dac_data_o); end
  endtask

  task automatic quick_cycle();
    step();
    u_if.ufeed_en_i = 1'b1; step(); u_if.ufeed_en_i = 1'b0;
    u_if.pid_done_i = 1'b1; step(); u_if.pid_done_i = 1'b0;
    u_if.dac_ack_i = 1'b1; step(); u_if.dac_ack_i = 1'b0;
  endtask

  task automatic test_rate_change();
    bit ok;
    int n;
    int rd0;
    loop_en = 1'b1; step();
    wait_read(150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rate_wait_read got=timeout exp=READ"); end
    quick_cycle();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rate_back got=%0d exp=1", state); end
    repeat (10) step();
    freq = 2'd2;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (u_if.rd_req_o) begin n = i; break; end
    end
    checks++; if (n != 34) begin errors++; $display("FAIL rate_first_tick got=%0d exp=34", n); end
    quick_cycle();
    freq = 2'd3;
    rd0 = rd_cnt;
    repeat (200) step();
    checks++; if (rd_cnt != rd0 || state !== 3'd1) begin errors++; $display("FAIL rate_disabled got=%0d/%0d exp=0/1", rd_cnt - rd0, state); end
  endtask

  task automatic test_async_reset();
    bit ok;
    freq = 2'd2;
    wait_read(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_wait_read got=timeout exp=READ"); end
    step();
    checks++; if (state !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL ar_in_feed got=%0d/%b exp=3/1", state, busy); end
    #3 rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL ar_state got=%0d/%b exp=0/0", state, busy); end
    checks++; if (u_if.dac_data_o !== 16'h0) begin errors++; $display("FAIL ar_dac got=%h exp=0000", u_if.dac_data_o); end
    checks++; if (u_if.rd_req_o !== 1'b0 || u_if.dac_wr_en_o !== 1'b0) begin errors++; $display("FAIL ar_strobes got=%b/%b exp=0/0", u_if.rd_req_o, u_if.dac_wr_en_o); end
    checks++; if (tmo !== 1'b0 || ovr !== 16'h0) begin errors++; $display("FAIL ar_flags got=%b/%0d exp=0/0", tmo, ovr); end
    step(); rst = 1'b0;
    wait_read(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_wait_read2 got=timeout exp=READ"); end
    step();
    u_if.ufeed_en_i = 1'b1; step(); u_if.ufeed_en_i = 1'b0;
    u_if.pid_done_i = 1'b1; step(); u_if.pid_done_i = 1'b0;
    checks++; if (u_if.dac_wr_en_o !== 1'b1) begin errors++; $display("FAIL ar_write got=%b exp=1", u_if.dac_wr_en_o); end
    #3 rst = 1'b1;
    #1;
    checks++; if (u_if.dac_wr_en_o !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL ar_write_drop got=%b/%0d exp=0/0", u_if.dac_wr_en_o, state); end
    step(); rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_overrun();
    test_normal();
    test_timeout();
    test_abort();
    test_rate_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/motor_loop_seq.md
MOTOR_LOOP_SEQ -- requirements
Module: motor_loop_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PERIOD_100HZ, 1000000, tick period in clk_i cycles for motor_freq_i=0
- PERIOD_200HZ, 500000, tick period for motor_freq_i=1
- PERIOD_300HZ, 333333, tick period for motor_freq_i=2
- TIMEOUT_CYC, 4096, maximum wait per handshake phase

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- loop_en_i  in  1  closed-loop sequencing enable.
- motor_freq_i  in  2  loop rate select: 0=100Hz, 1=200Hz, 2=300Hz, 3=ticks disabled.
- err_clr_i  in  1  pulse; clears timeout_err_o and overrun_cnt_o.
- rd_req_o  out  1  one-cycle request to sample the feedback voltage (Ufeed).
- ufeed_en_i  in  1  feedback sample valid.
- pid_start_o  out  1  one-cycle launch of the PID datapath.
- pid_done_i  in  1  PID result valid.
- pid_data_i  in  16  PID result.
- dac_wr_en_o  out  1  DAC write request; level signal, held until acknowledged.
- dac_data_o  out  16  DAC code.
- dac_ack_i  in  1  DAC write accepted.
- busy_o  out  1  high in READ, WAIT_FEED, CALC and WRITE.
- state_o  out  3  current state encoding.
- timeout_err_o  out  1  sticky timeout flag.
- overrun_cnt_o  out  16  count of dropped ticks; saturates.

Function
REQ-003 The tick counter SHALL count 0..P-1, where P is selected by motor_freq_i, and SHALL emit an internal one-cycle tick when the count wraps to 0.
REQ-004 When motor_freq_i changes, or when motor_freq_i=3, the counter SHALL reset to 0 and no tick SHALL be emitted.
REQ-005 The FSM states SHALL be IDLE=0, WAIT_TICK=1, READ=2, WAIT_FEED=3, CALC=4, WRITE=5.
REQ-006 Transitions SHALL be:
- IDLE -> WAIT_TICK when loop_en_i=1.
- WAIT_TICK -> READ on tick.
- READ -> WAIT_FEED unconditionally after one cycle.
- WAIT_FEED -> CALC on ufeed_en_i.
- CALC -> WRITE on pid_done_i.
- WRITE -> WAIT_TICK on dac_ack_i.
REQ-007 rd_req_o SHALL be high only during the single READ cycle, which is the cycle after the tick.
REQ-008 pid_start_o SHALL pulse for one cycle on the first CALC cycle.
REQ-009 On pid_done_i in CALC, the block SHALL register pid_data_i into dac_data_o in the same clock edge that enters WRITE.
REQ-010 dac_wr_en_o SHALL be high for every WRITE cycle and SHALL drop in the cycle after dac_ack_i.
REQ-011 dac_data_o SHALL hold its value outside WRITE.
REQ-012 A phase counter SHALL clear on every state change and increment in WAIT_FEED, CALC and WRITE.
REQ-013 When the phase counter reaches TIMEOUT_CYC-1 without the awaited input, the FSM SHALL set timeout_err_o=1 and go to WAIT_TICK; dac_data_o SHALL keep its previous value.
REQ-014 If the awaited input and the timeout occur in the same cycle, the input SHALL win and no error SHALL be flagged.
REQ-015 A tick arriving while busy_o=1 SHALL be dropped and SHALL increment overrun_cnt_o, saturating at 0xFFFF; it SHALL NOT be queued.
REQ-016 A tick arriving in the same cycle as the WRITE->WAIT_TICK transition SHALL be counted as an overrun.
REQ-017 When loop_en_i=0 in any state, the FSM SHALL go to IDLE on the next edge, deassert rd_req_o, pid_start_o and dac_wr_en_o, and leave dac_data_o unchanged.
REQ-018 ufeed_en_i, pid_done_i and dac_ack_i SHALL be ignored outside their waiting states.
REQ-019 If err_clr_i coincides with a new timeout or overrun, the new event SHALL win: the flag is set, or the counter is 1.

Reset
REQ-020 On rst_i=1, asynchronously, the following SHALL hold: state=IDLE, all counters=0, rd_req_o=0, pid_start_o=0, dac_wr_en_o=0, dac_data_o=0, busy_o=0, timeout_err_o=0, overrun_cnt_o=0.
REQ-021 rst_i asserted mid-WRITE SHALL drop dac_wr_en_o immediately, without waiting for a clock edge.

Verification
REQ-022 Bench parameters SHALL be PERIOD_100HZ=100, PERIOD_200HZ=50, PERIOD_300HZ=33 and TIMEOUT_CYC=16. The bench SHALL cover these directed scenarios:
- Normal cycle: loop_en_i=1, freq=0; ufeed after 3 cycles, pid_done with 0x1234 after 5, ack after 2 -> one rd_req_o and one pid_start_o per 100 cycles, dac_data_o=0x1234, timeout_err_o=0.
- Timeout: pid_done_i never asserted -> timeout_err_o=1 exactly 16 cycles after CALC entry, state=1, dac_data_o unchanged; err_clr_i -> 0.
- Overrun: freq=1, dac_ack_i withheld for 120 cycles with TIMEOUT_CYC raised to 256 -> overrun_cnt_o=2.
- Abort: loop_en_i=0 in WRITE -> next cycle state=0 and dac_wr_en_o=0; later ack ignored.
- Rate change: freq 0->2 mid-count -> next tick 33 cycles after the change; freq=3 -> no rd_req_o for 200 cycles.
- Async reset mid-WAIT_FEED -> outputs at reset values before the next edge.
